// File: rtl/img_pkg.sv
// Shared state encoding, grayscale weights and header layout for the raster buffer.
package img_pkg;

    typedef enum logic [2:0] {IDLE, FILL, DISCARD, FLUSH, HEADER, DRAIN} state_t;

    localparam logic [15:0] GRAY_R = 16'd77;
    localparam logic [15:0] GRAY_G = 16'd150;
    localparam logic [15:0] GRAY_B = 16'd29;

    localparam int HDR_W_MSB = 31;
    localparam int HDR_H_MSB = 15;

    // The weights sum to 256, so the 16-bit accumulator never overflows.
    function automatic logic [7:0] rgb_to_gray(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
        logic [15:0] acc;
        acc = GRAY_R * {8'd0, r} + GRAY_G * {8'd0, g} + GRAY_B * {8'd0, b};
        return acc[15:8];
    endfunction

endpackage

// File: rtl/img_frame_ram.sv
// Simple dual-port frame store: byte-enabled write port, registered 1-cycle read port.
module img_frame_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: no reset on the array or its read register; a reset would stop block-RAM inference.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/img_raster_buffer.sv
// Collects decoded RGB pixels as grayscale in a frame RAM, then streams a header
// word and the raster-ordered image packed four pixels per word.
module img_raster_buffer
    import img_pkg::*;
#(
    parameter int MAX_W  = 64,
    parameter int MAX_H  = 64,
    parameter int ADDR_W = $clog2(MAX_W * MAX_H / 4)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_width,
    input  logic [15:0] in_height,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic        upstream_stall,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        downstream_stall,
    output logic        frame_err
);

    localparam int IDX_W = ADDR_W + 2;

    state_t            state;
    logic [15:0]       width_q, height_q;
    logic [31:0]       n_pix, pix_cnt;
    logic              flush_cnt;
    logic              s1_valid;
    logic [7:0]        s1_gray;
    logic [IDX_W-1:0]  s1_prod, s1_x, wr_idx;
    logic [ADDR_W:0]   rd_cnt, n_words;
    logic              rd_pend, rd_pend_last, skid_valid;
    logic [31:0]       skid_data, ram_q, rd_word, keep_mask, hdr_word, n_eff, cnt_next;
    logic [15:0]       width_eff, height_eff;
    logic              in_fire, first, good, frame_done, in_range, pop, rd_issue;
    logic [1:0]        held;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        in_fire    = in_valid && !upstream_stall;
        first      = (state == IDLE);
        width_eff  = first ? in_width  : width_q;
        height_eff = first ? in_height : height_q;
        n_eff      = first ? 32'(in_width) * 32'(in_height) : n_pix;
        cnt_next   = first ? 32'd1 : pix_cnt + 32'd1;
        frame_done = (cnt_next >= n_eff);
        good       = first ? !(in_width == 16'd0 || in_height == 16'd0 ||
                               in_width > 16'(MAX_W) || in_height > 16'(MAX_H))
                           : (state == FILL);
        in_range   = (in_x < width_eff) && (in_y < height_eff);
        wr_idx     = s1_prod + s1_x;

        // A read is only issued when the output register plus skid entry can absorb it.
        pop      = out_valid && !downstream_stall;
        held     = 2'(out_valid && !pop) + 2'(skid_valid) + 2'(rd_pend);
        rd_issue = (state == DRAIN) && (rd_cnt != n_words) && (held < 2'd2);

        case (n_pix[1:0])
            2'd1:    keep_mask = 32'h0000_00FF;
            2'd2:    keep_mask = 32'h0000_FFFF;
            2'd3:    keep_mask = 32'h00FF_FFFF;
            default: keep_mask = 32'hFFFF_FFFF;
        endcase
        rd_word = ram_q & (rd_pend_last ? keep_mask : 32'hFFFF_FFFF);

        hdr_word = '0;
        hdr_word[HDR_W_MSB -: 16] = width_q;
        hdr_word[HDR_H_MSB -: 16] = height_q;
    end

    img_frame_ram #(.DEPTH(MAX_W * MAX_H / 4), .ADDR_W(ADDR_W)) u_ram (
        .clock   (clock),
        .wr_en   (s1_valid),
        .wr_addr (wr_idx[IDX_W-1:2]),
        .wr_be   (4'b0001 << wr_idx[1:0]),
        .wr_data ({4{s1_gray}}),
        .rd_en   (rd_issue),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_data (ram_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            upstream_stall <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            frame_err      <= 1'b0;
            width_q        <= '0;
            height_q       <= '0;
            n_pix          <= '0;
            pix_cnt        <= '0;
            flush_cnt      <= 1'b0;
            s1_valid       <= 1'b0;
            s1_gray        <= '0;
            s1_prod        <= '0;
            s1_x           <= '0;
            rd_cnt         <= '0;
            n_words        <= '0;
            rd_pend        <= 1'b0;
            rd_pend_last   <= 1'b0;
            skid_valid     <= 1'b0;
            skid_data      <= '0;
        end else begin
            frame_err <= 1'b0;
            s1_valid  <= in_fire && good && in_range;
            s1_gray   <= rgb_to_gray(in_r, in_g, in_b);
            s1_prod   <= IDX_W'(in_y) * IDX_W'(width_eff);
            s1_x      <= IDX_W'(in_x);
            rd_pend   <= rd_issue;
            if (rd_issue) begin
                rd_cnt       <= rd_cnt + (ADDR_W+1)'(1);
                rd_pend_last <= (rd_cnt == n_words - (ADDR_W+1)'(1));
            end

            case (state)
                IDLE, FILL, DISCARD: begin
                    if (in_fire) begin
                        pix_cnt <= cnt_next;
                        if (first) begin
                            width_q  <= in_width;
                            height_q <= in_height;
                            n_pix    <= n_eff;
                        end
                        if (frame_done) begin
                            if (good) begin
                                state          <= FLUSH;
                                upstream_stall <= 1'b1;
                                flush_cnt      <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                frame_err <= 1'b1;
                            end
                        end else if (first) begin
                            state <= good ? FILL : DISCARD;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state     <= HEADER;
                        out_valid <= 1'b1;
                        out_data  <= hdr_word;
                        rd_cnt    <= '0;
                        n_words   <= (ADDR_W+1)'((n_pix + 32'd3) >> 2);
                    end
                end
                HEADER: begin
                    if (pop) begin
                        state     <= DRAIN;
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!out_valid || pop) begin
                        if (skid_valid) begin
                            out_data   <= skid_data;
                            out_valid  <= 1'b1;
                            skid_valid <= rd_pend;
                            skid_data  <= rd_word;
                        end else if (rd_pend) begin
                            out_data  <= rd_word;
                            out_valid <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                        if (pop && !skid_valid && !rd_pend && rd_cnt == n_words) begin
                            state          <= IDLE;
                            upstream_stall <= 1'b0;
                        end
                    end else if (rd_pend) begin
                        skid_valid <= 1'b1;
                        skid_data  <= rd_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_raster_buffer.sv
// Directed bench for img_raster_buffer: an array model of the frame predicts every output word.
module tb_img_raster_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid;
    logic [15:0] in_width, in_height, in_x, in_y;
    logic [7:0]  in_r, in_g, in_b;
    logic        upstream_stall;
    logic [31:0] out_data;
    logic        out_valid;
    logic        downstream_stall;
    logic        frame_err;

    always #5 clock = ~clock;

    img_raster_buffer dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_width         (in_width),
        .in_height        (in_height),
        .in_x             (in_x),
        .in_y             (in_y),
        .in_r             (in_r),
        .in_g             (in_g),
        .in_b             (in_b),
        .upstream_stall   (upstream_stall),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .downstream_stall (downstream_stall),
        .frame_err        (frame_err)
    );

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          err_pulses = 0;
    int          stall_seen = 0;
    logic [31:0] exp_q[$];
    int          img[4096];
    int          order3[9]  = '{4, 0, 8, 2, 6, 1, 7, 3, 5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    function automatic int gray_of(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    // Expected stream for a w x h frame: header, then raster bytes four per word, padding zeroed.
    task automatic model_frame(input int w, input int h);
        int          n;
        logic [31:0] word;
        n = w * h;
        exp_q.push_back({16'(w), 16'(h)});
        for (int j = 0; j < (n + 3) / 4; j++) begin
            word = '0;
            for (int k = 0; k < 4; k++)
                if (4 * j + k < n) word[8*k +: 8] = 8'(img[4*j + k]);
            exp_q.push_back(word);
        end
    endtask

    task automatic send_pixel(input int w, input int h, input int x, input int y,
                              input int r, input int g, input int b);
        int t = 0;
        in_valid  = 1'b1;
        in_width  = 16'(w);
        in_height = 16'(h);
        in_x      = 16'(x);
        in_y      = 16'(y);
        in_r      = 8'(r);
        in_g      = 8'(g);
        in_b      = 8'(b);
        if (x < w && y < h && w <= 64 && h <= 64) img[y*w + x] = gray_of(r, g, b);
        @(negedge clock);
        while (upstream_stall && t < 200) begin
            stall_seen++;
            t++;
            @(negedge clock);
        end
        if (t == 200) check("accept_timeout", 32'(t), 32'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_drain(input bit pat, input int stop_at);
        int cyc = 0;
        while (exp_q.size() > stop_at && cyc < 3000) begin
            @(posedge clock);
            #1;
            downstream_stall = pat ? ((cyc % 3) != 2) : 1'b0;
            cyc++;
        end
        if (exp_q.size() > stop_at) check("drain_timeout", 32'(exp_q.size()), 32'(stop_at));
        downstream_stall = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Every cycle with valid output is compared against the head of the expected stream.
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_err) err_pulses++;
            if (out_valid) begin
                if (exp_q.size() == 0) check("out_idle", 32'(out_valid), 32'd0);
                else begin
                    check("out_word", out_data, exp_q[0]);
                    if (!downstream_stall) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        in_valid = 1'b0; in_width = '0; in_height = '0; in_x = '0; in_y = '0;
        in_r = '0; in_g = '0; in_b = '0; downstream_stall = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_upstream_stall", 32'(upstream_stall), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 4x2 raster frame, pixel k is grey level k+1
        stall_seen = 0;
        for (int k = 0; k < 8; k++) send_pixel(4, 2, k % 4, k / 4, k + 1, k + 1, k + 1);
        check("fill_no_stall", 32'(stall_seen), 32'd0);
        model_frame(4, 2);
        check("pin_4x2_hdr", exp_q[0], 32'h0004_0002);
        check("pin_4x2_w0", exp_q[1], 32'h0403_0201);
        check("pin_4x2_w1", exp_q[2], 32'h0807_0605);
        run_drain(1'b0, 0);
        idle(5);

        // 8x8 coloured frame drained under a 1,1,0 stall pattern
        for (int k = 0; k < 64; k++)
            send_pixel(8, 8, k % 8, k / 8, (k * 37) % 256, (k * 11 + 5) % 256, 255 - k * 3);
        model_frame(8, 8);
        check("pin_8x8_len", 32'(exp_q.size()), 32'd17);
        run_drain(1'b1, 0);
        idle(5);

        // 3x3 frame in shuffled order; last word padding must be masked over stale data
        for (int i = 0; i < 9; i++)
            send_pixel(3, 3, order3[i] % 3, order3[i] / 3,
                       16 + order3[i], 16 + order3[i], 16 + order3[i]);
        model_frame(3, 3);
        check("pin_3x3_hdr", exp_q[0], 32'h0003_0003);
        check("pin_3x3_w0", exp_q[1], 32'h1312_1110);
        check("pin_3x3_w1", exp_q[2], 32'h1716_1514);
        check("pin_3x3_w2", exp_q[3], 32'h0000_0018);
        run_drain(1'b0, 0);
        idle(5);

        // 1x1 pure red
        send_pixel(1, 1, 0, 0, 255, 0, 0);
        model_frame(1, 1);
        check("pin_red_hdr", exp_q[0], 32'h0001_0001);
        check("pin_red_w0", exp_q[1], 32'h0000_004C);
        run_drain(1'b0, 0);
        idle(5);

        // oversize 65x1 frame is discarded with a single error pulse
        err_pulses = 0;
        for (int k = 0; k < 64; k++) send_pixel(65, 1, k, 0, 1, 2, 3);
        idle(3);
        check("err_before_last", 32'(err_pulses), 32'd0);
        send_pixel(65, 1, 64, 0, 1, 2, 3);
        idle(4);
        check("err_after_last", 32'(err_pulses), 32'd1);
        send_pixel(1, 1, 0, 0, 32, 32, 32);
        model_frame(1, 1);
        check("pin_after_err_w0", exp_q[1], 32'h0000_0020);
        run_drain(1'b0, 0);
        idle(5);

        // reset in the middle of draining a 4x4 frame
        for (int k = 0; k < 16; k++) send_pixel(4, 4, k % 4, k / 4, 160 + k, 160 + k, 160 + k);
        model_frame(4, 4);
        run_drain(1'b0, 3);
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_upstream_stall", 32'(upstream_stall), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) send_pixel(2, 2, k % 2, k / 2, k + 1, k + 1, k + 1);
        model_frame(2, 2);
        check("pin_2x2_w0", exp_q[1], 32'h0403_0201);
        run_drain(1'b0, 0);
        idle(8);
        check("all_words_seen", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
